// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
// Imported by the sequencer top; the state enum is visible for any checker that binds in.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT     = 2'd0,
    RESET_WAIT = 2'd1,
    START_WAIT = 2'd2,
    DONE       = 2'd3
  } seq_state_e;

  // Counter must hold the longest single wait: the reset wait or the full start window.
  function automatic int cnt_width(input int reset_cycles, input int start_cycles,
                                   input int starts, input int stagger);
    int longest;
    longest = (stagger != 0) ? starts * start_cycles : start_cycles;
    if (reset_cycles > longest) longest = reset_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset synchronizer: asserts asynchronously with reset_n, deasserts STAGES edges
// after reset_n goes high.
module reset_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  output logic rst_sync
);

  logic [STAGES-1:0] chain_q;

  // Shift ones in once reset_n is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) chain_q <= '0;
    else          chain_q <= {chain_q[STAGES-2:0], 1'b1};
  end

  assign rst_sync = chain_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Cycle-counted release of reset, start and delay-config lines with soft-reset re-run.
// Reset bits release together; start bits release together or staggered by START_CYCLES.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int RESETS       = 1,
  parameter int STARTS       = 0,
  parameter int DELAYS       = 0,
  parameter int RESET_CYCLES = 10,
  parameter int START_CYCLES = 10,
  parameter int STAGGER      = 0,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  soft_reset_req,
  input  logic [((DELAYS > 0) ? DELAYS : 1)-1:0] delay_cfg,
  output logic [RESETS+STARTS+DELAYS-1:0]       reset_n_out,
  output logic                                  busy,
  output logic                                  seq_done
);

  localparam int OW       = RESETS + STARTS + DELAYS;
  localparam int DW       = (DELAYS > 0) ? DELAYS : 1;
  localparam int SW       = (STARTS > 0) ? STARTS : 1;
  localparam int CW       = cnt_width(RESET_CYCLES, START_CYCLES, STARTS, STAGGER);
  localparam int LAST_THR = (STAGGER != 0) ? STARTS * START_CYCLES : START_CYCLES;

  if (RESETS < 1)       begin : g_chk_resets $error("RESETS must be >= 1"); end
  if (RESET_CYCLES < 1) begin : g_chk_rc     $error("RESET_CYCLES must be >= 1"); end
  if (START_CYCLES < 1) begin : g_chk_sc     $error("START_CYCLES must be >= 1"); end
  if (SYNC_STAGES < 2)  begin : g_chk_sync   $error("SYNC_STAGES must be >= 2"); end

  logic          rst_sync;
  seq_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          rel_q, rel_d;
  logic [SW-1:0] start_q, start_d;
  logic [DW-1:0] dly_q, dly_d;
  logic          done_q, done_d;
  logic          busy_q;
  logic          soft_hold_q;
  logic [OW-1:0] out_s;

  reset_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .rst_sync (rst_sync)
  );

  function automatic logic [CW-1:0] start_thr(input int idx);
    if (STAGGER != 0) start_thr = CW'((idx + 1) * START_CYCLES);
    else              start_thr = CW'(START_CYCLES);
  endfunction

  // Next-state, counter and release decisions; a soft request overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    start_d = start_q;
    done_d  = done_q;
    cnt_inc = cnt_q + CW'(1);
    if (state_q == ASSERT) dly_d = delay_cfg;
    else                   dly_d = dly_q;

    if (soft_reset_req) begin
      state_d = ASSERT;
      cnt_d   = '0;
      rel_d   = 1'b0;
      start_d = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        // The exit edge from ASSERT is the first counted edge; soft_hold_q keeps
        // ASSERT one extra edge after a soft request.
        ASSERT, RESET_WAIT: begin
          if (soft_hold_q) begin
            cnt_d = '0;
          end else if (cnt_inc == CW'(RESET_CYCLES)) begin
            rel_d = 1'b1;
            cnt_d = '0;
            if (STARTS > 0) begin
              state_d = START_WAIT;
            end else begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d   = cnt_inc;
            state_d = RESET_WAIT;
          end
        end
        START_WAIT: begin
          cnt_d = cnt_inc;
          for (int j = 0; j < SW; j++) begin
            if (cnt_inc >= start_thr(j)) start_d[j] = 1'b1;
            else                         start_d[j] = start_q[j];
          end
          if (cnt_inc >= CW'(LAST_THR)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = START_WAIT;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = ASSERT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Sequencing registers, held in reset by the synchronized reset.
  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      state_q     <= ASSERT;
      cnt_q       <= '0;
      rel_q       <= 1'b0;
      start_q     <= '0;
      dly_q       <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b1;
      soft_hold_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rel_q       <= rel_d;
      start_q     <= start_d;
      dly_q       <= dly_d;
      done_q      <= done_d;
      busy_q      <= ~done_d;
      soft_hold_q <= soft_reset_req;
    end
  end

  // Pack resets, starts and delays onto the output bus.
  always_comb begin
    out_s              = '0;
    out_s[RESETS-1:0]  = {RESETS{rel_q}};
    for (int j = 0; j < STARTS; j++) out_s[RESETS+j] = start_q[j];
    for (int k = 0; k < DELAYS; k++) out_s[RESETS+STARTS+k] = dly_q[k];
  end

  assign reset_n_out = out_s;
  assign busy        = busy_q;
  assign seq_done    = done_q;

endmodule
